// File: rtl/sim_monitor_pkg.sv
// Shared types and helpers for the end-of-test simulation monitor.
package sim_monitor_pkg;

  typedef enum logic [2:0] {IDLE, RUN, CHECK, PASS, FAIL, TIMEOUT} state_t;

  localparam logic [15:0] FAIL_EXIT = 16'hFFFF;

  // Byte address to word index; the two low address bits never take part in matching.
  function automatic logic [31:0] word_of(input logic [31:0] byte_addr);
    return {2'b00, byte_addr[31:2]};
  endfunction

endpackage

// File: rtl/sim_monitor_order_cmp.sv
// Single order comparator: ok is high when a (earlier word) and b (later word) are in order.
module order_cmp #(
  parameter int DATA_W     = 32,
  parameter bit SIGNED_CMP = 1'b1,
  parameter bit DESCENDING = 1'b0
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              ok
);

  logic a_le_b;
  logic a_ge_b;

  always_comb begin
    if (SIGNED_CMP) begin
      a_le_b = $signed(a) <= $signed(b);
      a_ge_b = $signed(a) >= $signed(b);
    end else begin
      a_le_b = a <= b;
      a_ge_b = a >= b;
    end
    ok = DESCENDING ? a_ge_b : a_le_b;
  end

endmodule

// File: rtl/sim_monitor.sv
// End-of-test monitor: shadows a DMEM region, waits for a TOHOST exit write,
// then scans the shadow one word per cycle for sorted order.
module sim_monitor
  import sim_monitor_pkg::*;
#(
  parameter int          ADDR_W       = 10,
  parameter int          DATA_W       = 32,
  parameter int          MAX_CYCLES   = 3000,
  parameter logic [31:0] TOHOST_ADDR  = 32'h3FC,
  parameter logic [31:0] REGION_BASE  = 32'h000,
  parameter int          REGION_WORDS = 16,
  parameter bit          SIGNED_CMP   = 1'b1,
  parameter bit          DESCENDING   = 1'b0
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [ADDR_W-1:0] address_DMEM,
  input  logic [DATA_W-1:0] write_data_DMEM,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [DATA_W-1:0] exit_code,
  output logic [15:0]       fail_idx,
  output logic [31:0]       cycle_count,
  output logic [31:0]       wr_count,
  output logic [31:0]       rd_count
);

  localparam int          IDX_W       = $clog2(REGION_WORDS);
  localparam logic [31:0] BASE_WORD   = word_of(REGION_BASE);
  localparam logic [31:0] END_WORD    = BASE_WORD + 32'(REGION_WORDS);
  localparam logic [31:0] TOHOST_WORD = word_of(TOHOST_ADDR);

  state_t            state;
  state_t            next_state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  prev_idx;
  logic [DATA_W-1:0] shadow [REGION_WORDS];
  logic [REGION_WORDS-1:0] mask;

  logic [31:0]       bus_word;
  logic              in_region;
  logic              is_tohost;
  logic [IDX_W-1:0]  wr_idx;
  logic              order_ok;
  logic              fail_load;
  logic [15:0]       fail_val;

  assign bus_word  = word_of(32'(address_DMEM));
  assign in_region = (bus_word >= BASE_WORD) && (bus_word < END_WORD);
  assign is_tohost = (bus_word == TOHOST_WORD);
  assign wr_idx    = IDX_W'(bus_word - BASE_WORD);
  assign prev_idx  = (idx == '0) ? idx : idx - IDX_W'(1);

  order_cmp #(
    .DATA_W    (DATA_W),
    .SIGNED_CMP(SIGNED_CMP),
    .DESCENDING(DESCENDING)
  ) u_cmp (
    .a (shadow[prev_idx]),
    .b (shadow[idx]),
    .ok(order_ok)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= IDLE;
    else       state <= next_state;
  end

  // A TOHOST write on the watchdog's last cycle takes priority over TIMEOUT.
  always_comb begin
    next_state = state;
    fail_load  = 1'b0;
    fail_val   = '0;
    case (state)
      IDLE: next_state = RUN;
      RUN: begin
        if (MemWrite && is_tohost) begin
          if (write_data_DMEM != '0) begin
            next_state = FAIL;
            fail_load  = 1'b1;
            fail_val   = FAIL_EXIT;
          end else begin
            next_state = CHECK;
          end
        end else if (cycle_count == 32'(MAX_CYCLES - 1)) begin
          next_state = TIMEOUT;
        end
      end
      CHECK: begin
        if (!mask[idx] || (idx != '0 && !order_ok)) begin
          next_state = FAIL;
          fail_load  = 1'b1;
          fail_val   = 16'(idx);
        end else if (idx == IDX_W'(REGION_WORDS - 1)) begin
          next_state = PASS;
        end
      end
      default: next_state = state;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      idx         <= '0;
      mask        <= '0;
      exit_code   <= '0;
      fail_idx    <= '0;
      cycle_count <= '0;
      wr_count    <= '0;
      rd_count    <= '0;
      for (int i = 0; i < REGION_WORDS; i++) shadow[i] <= '0;
    end else begin
      if (state == RUN) begin
        idx <= '0;
        if (cycle_count != '1) cycle_count <= cycle_count + 32'd1;
        if (MemWrite && wr_count != '1) wr_count <= wr_count + 32'd1;
        if (MemRead && rd_count != '1) rd_count <= rd_count + 32'd1;
        if (MemWrite && in_region) begin
          shadow[wr_idx] <= write_data_DMEM;
          mask[wr_idx]   <= 1'b1;
        end
        if (MemWrite && is_tohost) exit_code <= write_data_DMEM;
      end
      if (state == CHECK && next_state == CHECK) idx <= idx + IDX_W'(1);
      if (fail_load) fail_idx <= fail_val;
    end
  end

  assign done    = (state == PASS) || (state == FAIL) || (state == TIMEOUT);
  assign pass    = (state == PASS);
  assign timeout = (state == TIMEOUT);

endmodule

// File: tb/tb_sim_monitor.sv
// Directed bench for sim_monitor: signed ascending monitor plus unsigned and descending variants.
module tb_sim_monitor;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [9:0]  address_DMEM = '0;
  logic [31:0] write_data_DMEM = '0;

  logic        done, pass, timeout;
  logic [31:0] exit_code, cycle_count, wr_count, rd_count;
  logic [15:0] fail_idx;
  logic        u_done, u_pass, u_timeout;
  logic [31:0] u_exit_code, u_cycle_count, u_wr_count, u_rd_count;
  logic [15:0] u_fail_idx;
  logic        d_done, d_pass, d_timeout;
  logic [31:0] d_exit_code, d_cycle_count, d_wr_count, d_rd_count;
  logic [15:0] d_fail_idx;

  int checks = 0;
  int errors = 0;
  logic [31:0] vec [16];

  always #5 CLK = ~CLK;

  sim_monitor #(.MAX_CYCLES(100), .SIGNED_CMP(1'b1), .DESCENDING(1'b0)) dut (
    .CLK(CLK), .RSTn(RSTn), .MemWrite(MemWrite), .MemRead(MemRead),
    .address_DMEM(address_DMEM), .write_data_DMEM(write_data_DMEM),
    .done(done), .pass(pass), .timeout(timeout), .exit_code(exit_code),
    .fail_idx(fail_idx), .cycle_count(cycle_count), .wr_count(wr_count), .rd_count(rd_count)
  );

  sim_monitor #(.MAX_CYCLES(100), .SIGNED_CMP(1'b0), .DESCENDING(1'b0)) dut_u (
    .CLK(CLK), .RSTn(RSTn), .MemWrite(MemWrite), .MemRead(MemRead),
    .address_DMEM(address_DMEM), .write_data_DMEM(write_data_DMEM),
    .done(u_done), .pass(u_pass), .timeout(u_timeout), .exit_code(u_exit_code),
    .fail_idx(u_fail_idx), .cycle_count(u_cycle_count), .wr_count(u_wr_count), .rd_count(u_rd_count)
  );

  sim_monitor #(.MAX_CYCLES(100), .SIGNED_CMP(1'b1), .DESCENDING(1'b1)) dut_d (
    .CLK(CLK), .RSTn(RSTn), .MemWrite(MemWrite), .MemRead(MemRead),
    .address_DMEM(address_DMEM), .write_data_DMEM(write_data_DMEM),
    .done(d_done), .pass(d_pass), .timeout(d_timeout), .exit_code(d_exit_code),
    .fail_idx(d_fail_idx), .cycle_count(d_cycle_count), .wr_count(d_wr_count), .rd_count(d_rd_count)
  );

  // Leaves the bench at the negedge after the IDLE edge, i.e. in RUN with cycle_count 0.
  task automatic do_reset();
    MemWrite = 1'b0; MemRead = 1'b0; address_DMEM = '0; write_data_DMEM = '0;
    RSTn = 1'b0;
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
  endtask

  task automatic bus_cycle(input logic we, input logic re, input logic [9:0] a, input logic [31:0] d);
    MemWrite = we; MemRead = re; address_DMEM = a; write_data_DMEM = d;
    @(negedge CLK);
    MemWrite = 1'b0; MemRead = 1'b0;
  endtask

  task automatic write_vec(input logic re, input int skip, input bit misalign);
    for (int i = 0; i < 16; i++)
      if (i != skip) bus_cycle(1'b1, re, 10'(4 * i + (misalign ? i % 4 : 0)), vec[i]);
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    #1;
    checks++;
    if ({done, pass, timeout} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {done, pass, timeout});
    end
    checks++;
    if ({exit_code, fail_idx, cycle_count, wr_count, rd_count} !== '0) begin
      errors++; $display("FAIL reset_values: got ec=%h fi=%h cc=%0d wr=%0d rd=%0d want all 0",
                         exit_code, fail_idx, cycle_count, wr_count, rd_count);
    end
  endtask

  task automatic test_ascending_pass();
    do_reset();
    for (int i = 0; i < 16; i++) vec[i] = 32'(i + 1);
    write_vec(1'b1, 16, 1'b0);
    bus_cycle(1'b1, 1'b0, 10'h3FC, 32'h0);
    repeat (15) @(negedge CLK);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL asc_not_done_early: got %b want 0", done); end
    @(negedge CLK);
    checks++;
    if ({done, pass, timeout} !== 3'b110) begin
      errors++; $display("FAIL asc_pass: got %b want 110", {done, pass, timeout});
    end
    checks++;
    if (fail_idx !== 16'h0 || exit_code !== 32'h0) begin
      errors++; $display("FAIL asc_codes: got fi=%h ec=%h want 0 0", fail_idx, exit_code);
    end
    checks++;
    if (cycle_count !== 32'd17 || wr_count !== 32'd17 || rd_count !== 32'd16) begin
      errors++; $display("FAIL asc_counts: got cc=%0d wr=%0d rd=%0d want 17 17 16",
                         cycle_count, wr_count, rd_count);
    end
    checks++;
    if (d_fail_idx !== 16'd1 || d_pass !== 1'b0) begin
      errors++; $display("FAIL asc_desc_variant: got fi=%0d pass=%b want 1 0", d_fail_idx, d_pass);
    end
    bus_cycle(1'b1, 1'b1, 10'h3FC, 32'h55);
    bus_cycle(1'b1, 1'b0, 10'h000, 32'd999);
    repeat (3) @(negedge CLK);
    checks++;
    if (pass !== 1'b1 || exit_code !== 32'h0 || cycle_count !== 32'd17 || wr_count !== 32'd17) begin
      errors++; $display("FAIL asc_terminal: got pass=%b ec=%h cc=%0d wr=%0d want 1 0 17 17",
                         pass, exit_code, cycle_count, wr_count);
    end
  endtask

  task automatic test_order_break();
    do_reset();
    for (int i = 0; i < 16; i++) vec[i] = 32'(i + 1);
    vec[5] = 32'h0;
    write_vec(1'b0, 16, 1'b0);
    bus_cycle(1'b1, 1'b0, 10'h3FC, 32'h0);
    repeat (5) @(negedge CLK);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL brk_not_done_early: got %b want 0", done); end
    @(negedge CLK);
    checks++;
    if ({done, pass} !== 2'b10 || fail_idx !== 16'd5) begin
      errors++; $display("FAIL brk_fail5: got done=%b pass=%b fi=%0d want 1 0 5", done, pass, fail_idx);
    end
  endtask

  task automatic test_signed_unsigned();
    do_reset();
    vec[0] = -32'sd3; vec[1] = -32'sd1; vec[2] = 32'd0; vec[3] = 32'd7;
    for (int i = 4; i < 16; i++) vec[i] = 32'(i + 4);
    write_vec(1'b0, 16, 1'b0);
    bus_cycle(1'b1, 1'b0, 10'h3FC, 32'h0);
    repeat (16) @(negedge CLK);
    checks++;
    if (pass !== 1'b1) begin errors++; $display("FAIL signed_pass: got %b want 1", pass); end
    checks++;
    if ({u_done, u_pass} !== 2'b10 || u_fail_idx !== 16'd2) begin
      errors++; $display("FAIL unsigned_fail: got done=%b pass=%b fi=%0d want 1 0 2",
                         u_done, u_pass, u_fail_idx);
    end
  endtask

  task automatic test_descending();
    do_reset();
    for (int i = 0; i < 16; i++) vec[i] = 32'(16 - i);
    write_vec(1'b0, 16, 1'b0);
    bus_cycle(1'b1, 1'b0, 10'h3FC, 32'h0);
    repeat (16) @(negedge CLK);
    checks++;
    if (d_pass !== 1'b1) begin errors++; $display("FAIL desc_pass: got %b want 1", d_pass); end
    checks++;
    if (pass !== 1'b0 || fail_idx !== 16'd1) begin
      errors++; $display("FAIL desc_on_asc_monitor: got pass=%b fi=%0d want 0 1", pass, fail_idx);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (99) @(negedge CLK);
    checks++;
    if (done !== 1'b0 || cycle_count !== 32'd99) begin
      errors++; $display("FAIL to_before: got done=%b cc=%0d want 0 99", done, cycle_count);
    end
    @(negedge CLK);
    checks++;
    if ({done, pass, timeout} !== 3'b101 || cycle_count !== 32'd100) begin
      errors++; $display("FAIL to_hit: got flags=%b cc=%0d want 101 100", {done, pass, timeout}, cycle_count);
    end
    repeat (4) @(negedge CLK);
    checks++;
    if (timeout !== 1'b1 || cycle_count !== 32'd100) begin
      errors++; $display("FAIL to_frozen: got to=%b cc=%0d want 1 100", timeout, cycle_count);
    end
  endtask

  task automatic test_tohost_last_cycle();
    do_reset();
    for (int i = 0; i < 16; i++) vec[i] = 32'(i * 3);
    write_vec(1'b0, 16, 1'b0);
    repeat (83) @(negedge CLK);
    checks++;
    if (cycle_count !== 32'd99) begin
      errors++; $display("FAIL last_cc: got %0d want 99", cycle_count);
    end
    bus_cycle(1'b1, 1'b0, 10'h3FC, 32'h0);
    checks++;
    if (timeout !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL last_no_timeout: got to=%b done=%b want 0 0", timeout, done);
    end
    repeat (16) @(negedge CLK);
    checks++;
    if (pass !== 1'b1 || timeout !== 1'b0 || cycle_count !== 32'd100) begin
      errors++; $display("FAIL last_pass: got pass=%b to=%b cc=%0d want 1 0 100", pass, timeout, cycle_count);
    end
  endtask

  task automatic test_exit_and_missing();
    do_reset();
    bus_cycle(1'b1, 1'b0, 10'h3FC, 32'h2A);
    checks++;
    if (done !== 1'b1 || pass !== 1'b0 || fail_idx !== 16'hFFFF || exit_code !== 32'h2A) begin
      errors++; $display("FAIL exit_nonzero: got done=%b pass=%b fi=%h ec=%h want 1 0 ffff 2a",
                         done, pass, fail_idx, exit_code);
    end
    do_reset();
    for (int i = 0; i < 16; i++) vec[i] = 32'(i + 1);
    write_vec(1'b0, 9, 1'b0);
    bus_cycle(1'b1, 1'b0, 10'h3FC, 32'h0);
    repeat (10) @(negedge CLK);
    checks++;
    if (done !== 1'b1 || pass !== 1'b0 || fail_idx !== 16'd9) begin
      errors++; $display("FAIL missing_word9: got done=%b pass=%b fi=%0d want 1 0 9", done, pass, fail_idx);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus_cycle(1'b1, 1'b0, 10'h000, 32'd500);
    for (int i = 0; i < 16; i++) vec[i] = 32'(10 * i);
    write_vec(1'b0, 16, 1'b1);
    bus_cycle(1'b1, 1'b0, 10'h3FD, 32'h0);
    repeat (16) @(negedge CLK);
    checks++;
    if (pass !== 1'b1 || wr_count !== 32'd18) begin
      errors++; $display("FAIL unaligned_lastwins: got pass=%b wr=%0d want 1 18", pass, wr_count);
    end
  endtask

  task automatic test_mid_check_reset();
    do_reset();
    for (int i = 0; i < 16; i++) vec[i] = 32'(i + 1);
    write_vec(1'b0, 16, 1'b0);
    bus_cycle(1'b1, 1'b0, 10'h3FC, 32'h0);
    repeat (5) @(negedge CLK);
    #2 RSTn = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || cycle_count !== 32'd0 || wr_count !== 32'd0) begin
      errors++; $display("FAIL midreset_async: got done=%b cc=%0d wr=%0d want 0 0 0", done, cycle_count, wr_count);
    end
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    bus_cycle(1'b1, 1'b1, 10'h004, 32'd7);
    checks++;
    if (cycle_count !== 32'd1 || wr_count !== 32'd1 || rd_count !== 32'd1 || done !== 1'b0) begin
      errors++; $display("FAIL midreset_resume: got cc=%0d wr=%0d rd=%0d done=%b want 1 1 1 0",
                         cycle_count, wr_count, rd_count, done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_ascending_pass();
    test_order_break();
    test_signed_unsigned();
    test_descending();
    test_timeout();
    test_tohost_last_cycle();
    test_exit_and_missing();
    test_back_to_back();
    test_mid_check_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
